// File: rtl/pwm_pkg.sv
// Shared types and helpers for the level-driven PWM block.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    localparam int WIDTH_DEF = 4;

    function automatic int period_len(input int width);
        return 32'sd1 << width;
    endfunction

endpackage

// File: rtl/pwm_nivel_gerador_tick.sv
// Prescaler: emits one tick every PRESCALE clocks while not cleared.
module gerador_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt_r;

    // Prescale counter, held at zero while cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            pre_cnt_r <= {CW{1'b0}};
        end else if (pre_cnt_r == LAST) begin
            pre_cnt_r <= {CW{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + CW'(1);
        end
    end

    assign tick = !clear && (pre_cnt_r == LAST);

endmodule

// File: rtl/pwm_nivel.sv
// Level-to-PWM converter with a one-entry shadow register; duty changes
// only at period boundaries so no period is ever cut short.
module pwm_nivel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] nivel_in,
    input  logic             nivel_valid,
    output logic             nivel_ready,
    output logic             pwm_out,
    output logic             period_start
);

    localparam logic [WIDTH-1:0] PHASE_LAST = WIDTH'(period_len(WIDTH) - 1);

    estado_t          state_r, state_s;
    logic [WIDTH-1:0] phase_r, phase_s;
    logic [WIDTH-1:0] duty_r, duty_s;
    logic [WIDTH-1:0] shadow_r, shadow_s;
    logic             shadow_full_r, shadow_full_s;
    logic             period_start_r, period_start_s;
    logic             tick_s;
    logic             clear_s;
    logic             accept_s;

    // The prescaler restarts from zero whenever the PWM is not running.
    assign clear_s  = (state_r != RUN) || !enable;
    assign accept_s = nivel_valid && !shadow_full_r;

    gerador_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state, phase, duty and shadow decode.
    always_comb begin
        state_s        = state_r;
        phase_s        = phase_r;
        duty_s         = duty_r;
        shadow_s       = shadow_r;
        shadow_full_s  = shadow_full_r;
        period_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                phase_s = {WIDTH{1'b0}};
                if (enable) begin
                    state_s        = RUN;
                    period_start_s = 1'b1;
                    if (shadow_full_r) begin
                        duty_s        = shadow_r;
                        shadow_full_s = 1'b0;
                    end else begin
                        duty_s = duty_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_s = IDLE;
                    phase_s = {WIDTH{1'b0}};
                end else if (tick_s) begin
                    phase_s = phase_r + WIDTH'(1);
                    if (phase_r == PHASE_LAST) begin
                        period_start_s = 1'b1;
                        if (shadow_full_r) begin
                            duty_s        = shadow_r;
                            shadow_full_s = 1'b0;
                        end else begin
                            duty_s = duty_r;
                        end
                    end else begin
                        period_start_s = 1'b0;
                    end
                end else begin
                    phase_s = phase_r;
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = {WIDTH{1'b0}};
            end
        endcase
        // Accept only happens with the shadow empty, so it never races a load.
        if (accept_s) begin
            shadow_s      = nivel_in;
            shadow_full_s = 1'b1;
        end else begin
            shadow_s = shadow_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            phase_r        <= {WIDTH{1'b0}};
            duty_r         <= {WIDTH{1'b0}};
            shadow_r       <= {WIDTH{1'b0}};
            shadow_full_r  <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            phase_r        <= phase_s;
            duty_r         <= duty_s;
            shadow_r       <= shadow_s;
            shadow_full_r  <= shadow_full_s;
            period_start_r <= period_start_s;
        end
    end

    assign nivel_ready  = !shadow_full_r;
    assign pwm_out      = (state_r == RUN) && (phase_r < duty_r);
    assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_nivel.sv
// Scoreboard bench: two instances (PRESCALE 1 and 3) share stimulus and are
// compared against a cycles-since-period-start reference model.
module tb_pwm_nivel;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] nivel_in;
    logic       nivel_valid;
    logic       rdy0, pwm0, ps0;
    logic       rdy1, pwm1, ps1;

    int total = 0;
    int bad   = 0;

    pwm_nivel #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clock(clock), .reset(reset), .enable(enable),
        .nivel_in(nivel_in), .nivel_valid(nivel_valid),
        .nivel_ready(rdy0), .pwm_out(pwm0), .period_start(ps0)
    );

    pwm_nivel #(.WIDTH(4), .PRESCALE(3)) u_p3 (
        .clock(clock), .reset(reset), .enable(enable),
        .nivel_in(nivel_in), .nivel_valid(nivel_valid),
        .nivel_ready(rdy1), .pwm_out(pwm1), .period_start(ps1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state per instance
    int ps_div [2] = '{1, 3};
    bit m_run  [2];
    int m_k    [2];
    int m_duty [2];
    bit m_full [2];
    int m_pend [2];
    bit m_ps   [2];

    logic [5:0] exp_q[$];
    event push_ev;

    function automatic logic [2:0] exp_of(input int d);
        logic p;
        p = m_run[d] && ((m_k[d] / ps_div[d]) < m_duty[d]);
        return {p, m_ps[d], !m_full[d]};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 1'b0; m_k[d] = 0; m_duty[d] = 0;
            m_full[d] = 1'b0; m_pend[d] = 0; m_ps[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit en, input bit v, input int lvl);
        bit acc;
        for (int d = 0; d < 2; d++) begin
            acc = v && !m_full[d];
            m_ps[d] = 1'b0;
            if (!m_run[d]) begin
                if (en) begin
                    m_run[d] = 1'b1; m_k[d] = 0; m_ps[d] = 1'b1;
                    if (m_full[d]) begin m_duty[d] = m_pend[d]; m_full[d] = 1'b0; end
                end
            end else if (!en) begin
                m_run[d] = 1'b0; m_k[d] = 0;
            end else begin
                m_k[d] = m_k[d] + 1;
                if (m_k[d] == 16 * ps_div[d]) begin
                    m_k[d] = 0; m_ps[d] = 1'b1;
                    if (m_full[d]) begin m_duty[d] = m_pend[d]; m_full[d] = 1'b0; end
                end
            end
            if (acc) begin m_pend[d] = lvl; m_full[d] = 1'b1; end
        end
    endtask

    task automatic push_exp();
        exp_q.push_back({exp_of(1), exp_of(0)});
        -> push_ev;
    endtask

    // One clock cycle: drive after negedge, update model at posedge.
    task automatic step(input bit en, input bit v, input int lvl);
        enable = en; nivel_valid = v; nivel_in = 4'(lvl);
        @(posedge clock);
        model_edge(en, v, lvl);
        push_exp();
        @(negedge clock);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0; enable = 1'b0; nivel_valid = 1'b0;
        model_reset();
        push_exp();
        repeat (3) begin
            @(posedge clock);
            push_exp();
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations and compares against the live outputs.
    initial begin
        logic [5:0] e;
        forever begin
            @(push_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdy_p1", rdy0, e[0]);
                chk("ps_p1",  ps0,  e[1]);
                chk("pwm_p1", pwm0, e[2]);
                chk("rdy_p3", rdy1, e[3]);
                chk("ps_p3",  ps1,  e[4]);
                chk("pwm_p3", pwm1, e[5]);
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b0; enable = 1'b0; nivel_valid = 1'b0; nivel_in = 4'd0;
        model_reset();
        @(negedge clock);
        do_reset();
        repeat (2) step(1'b0, 1'b0, 0);

        // Basic duty 5, then mid-period update to 12 with a held follow-up sample
        step(1'b0, 1'b1, 5);
        step(1'b0, 1'b0, 0);
        repeat (19) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 12);
        repeat (15) step(1'b1, 1'b1, 7);
        repeat (40) step(1'b1, 1'b0, 0);

        // Extremes
        step(1'b1, 1'b1, 0);
        repeat (64) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 15);
        repeat (48) step(1'b1, 1'b0, 0);

        // Sample offered exactly in a boundary cycle of the PRESCALE=1 instance
        guard = 0;
        while (m_k[0] != 15 && guard < 40) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        step(1'b1, 1'b1, 9);
        repeat (40) step(1'b1, 1'b0, 0);

        // Mid-run async reset
        do_reset();
        step(1'b0, 1'b1, 4);
        repeat (100) step(1'b1, 1'b0, 0);

        // Disable at phase 2 of the PRESCALE=3 instance, then re-enable
        guard = 0;
        while ((m_k[1] / 3) != 2 && guard < 60) begin
            step(1'b1, 1'b0, 0);
            guard++;
        end
        repeat (3) step(1'b0, 1'b0, 0);
        repeat (100) step(1'b1, 1'b0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 19) != 0, $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, 15)));
            end
        end

        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_nivel.md
Name: pwm_nivel

Overview:
- Downstream consumer of the 4-bit level sequence produced by the up/down (triangle) counter.
- Converts each accepted level sample into a pulse-width-modulated output. The level sets the duty cycle of a 2^WIDTH-tick PWM period.
- Samples arrive through a valid/ready handshake into a one-entry shadow register. The active duty is updated only at period boundaries, so no PWM period is ever truncated or glitched.

Parameters:
- WIDTH, 4, level width; PWM period = 2^WIDTH ticks.
- PRESCALE, 1, clock cycles per PWM tick; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  1 = run the PWM, 0 = idle.
- nivel_in  input  WIDTH  level sample, unsigned.
- nivel_valid  input  1  nivel_in holds a valid sample.
- nivel_ready  output  1  shadow register is empty and can accept a sample.
- pwm_out  output  1  PWM waveform.
- period_start  output  1  one-cycle pulse when a new period begins.

Behaviour:
- Reset (reset=0, asynchronous): all registers return to fixed values.
  - state=IDLE, phase=0, pre_cnt=0, duty_active=0, shadow=0, shadow_full=0.
  - Outputs: pwm_out=0, period_start=0, nivel_ready=1.
- Reset mid-period: abandons the period immediately and discards any pending shadow sample.
- Handshake (active in IDLE and RUN):
  - nivel_ready = !shadow_full, decoded from registers only, with no combinational path from nivel_valid.
  - When nivel_valid && nivel_ready at an edge, shadow <= nivel_in and shadow_full <= 1.
  - Samples offered while ready=0 are not taken; the producer must hold them.
- State machine, IDLE:
  - pwm_out=0; phase and pre_cnt held at 0.
  - On enable=1, go to RUN at the next edge. On that same edge:
    - period_start <= 1;
    - if shadow_full, duty_active <= shadow and shadow_full <= 0.
- State machine, RUN:
  - pre_cnt counts 0..PRESCALE-1. A tick occurs in the cycle where pre_cnt==PRESCALE-1; pre_cnt then wraps to 0.
  - On a tick, phase <= phase+1, modulo 2^WIDTH.
  - A boundary is a tick with phase==2^WIDTH-1. At a boundary edge:
    - phase <= 0;
    - period_start <= 1 for exactly one cycle;
    - if shadow_full, duty_active <= shadow and shadow_full <= 0; otherwise duty_active is kept.
  - On enable=0, go to IDLE at the next edge. phase and pre_cnt clear to 0; duty_active and shadow are kept.
- Output rules:
  - pwm_out = (state==RUN) && (phase < duty_active), decoded from registers only.
  - duty 0 gives a constant 0 output.
  - duty D gives D high ticks followed by 2^WIDTH-D low ticks; maximum duty is 15/16 at WIDTH=4.
- Simultaneous accept and boundary in the same cycle:
  - Only possible with shadow empty.
  - The new sample enters shadow and is applied at the next boundary; there is no bypass into duty_active.
- Phase arithmetic is unsigned WIDTH-bit with natural wrap. The comparison is unsigned.

Decomposition:
- Shared package pwm_pkg:
  - typedef enum logic {IDLE, RUN} estado_t;
  - localparam default WIDTH;
  - function for period length (1 << WIDTH).
- One sub-module: gerador_tick.
  - Holds the PRESCALE counter.
  - Inputs: clock, reset, clear.
  - Output: tick.
  - clear is asserted while in IDLE.

Test Plan:
- Reset and default values: hold reset=0 for 3 cycles, then release with enable=0 → nivel_ready=1, pwm_out=0, period_start=0. Then assert reset=0 mid-RUN → all outputs drop in the same cycle, without waiting for an edge.
- Basic duty, PRESCALE=1: send level 5, then set enable=1 → period_start pulses once; pwm_out is high for 5 cycles and low for 11; the pattern repeats every 16 cycles.
- Boundary-aligned update: while running at duty 5, send level 12 at phase 3 → current period keeps 5 high cycles; next period (after period_start) has 12 high cycles. A second sample offered before the boundary sees nivel_ready=0 until the boundary edge.
- Extremes: level 0 → pwm_out never high across 3 periods. Level 15 → 15 high and 1 low per period.
- Simultaneous accept at boundary: shadow empty, and a valid sample of 9 arrives in the boundary cycle → duty for the next period is unchanged; the period after that uses 9.
- Prescaler and disable, PRESCALE=3, level 4: pwm_out high for 12 clocks per 48-clock period. Drop enable at phase 2 → pwm_out=0 next cycle, phase clears. Re-enable → a fresh period starts with period_start and duty 4 retained.
